axis_packet_rr_arb: RTL and testbench

//  - Packet-level round-robin arbiter that shares one AXI4-Stream datapath among PORTS sources.
//  - Sits in front of an axis_pipeline_fifo. A grant is held from the first beat of a packet to its tlast beat.
//  - Output is fully registered, with tid = index of the granted source.

---
 rtl/axis_packet_rr_arb.sv | 167 ++++++++++++++++
 tb/tb_axis_packet_rr_arb.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_rr_arb.sv
//------------------------------------------------------------------------------
// Module   : axis_packet_rr_arb
// Brief    : Packet-level round-robin arbiter that merges PORTS AXI4-Stream
//            sources onto one registered output stream. A grant is held from
//            the first beat of a packet up to and including its tlast beat,
//            and m_axis_tid carries the index of the granted source.
// Options  : AXIS_ARB_PRIO_EN - adds s_axis_prio; when any requester is
//            flagged high-priority, round-robin runs only among those.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_packet_rr_arb #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH = 1,
  parameter int IDX_WIDTH  = $clog2(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
`ifdef AXIS_ARB_PRIO_EN
  input  logic [PORTS-1:0]              s_axis_prio,
`endif
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [IDX_WIDTH-1:0]          m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          grant_idx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   valid_q;

  logic [DATA_WIDTH-1:0]  data_q;
  logic [KEEP_WIDTH-1:0]  keep_q;
  logic [USER_WIDTH-1:0]  user_q;
  logic                   tlast_q;
  logic [IDX_WIDTH-1:0]   tid_q;

  logic [PORTS-1:0]       req;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   pick_vld;
  logic                   out_ready;
  logic                   beat_acc;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_ready = !valid_q || m_axis_tready;

  // Request set presented to the round-robin search.
`ifdef AXIS_ARB_PRIO_EN
  logic [PORTS-1:0] hi_req;
  assign hi_req = s_axis_tvalid & s_axis_prio;
  assign req    = (|hi_req) ? hi_req : s_axis_tvalid;
`else
  assign req    = s_axis_tvalid;
`endif

  // Round-robin search starting after the last served port; nearest hit wins
  // because the loop walks from the farthest candidate to the nearest.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = last_q;
    pick_vld = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % PORTS;
      if (req[idx]) begin
        pick     = IDX_WIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Arbitration FSM: next state, grant bookkeeping and upstream readies.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    busy_d        = busy_q;
    s_axis_tready = '0;
    beat_acc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_axis_tready[grant_q] = out_ready;
        beat_acc               = s_axis_tvalid[grant_q] && out_ready;
        if (beat_acc && s_axis_tlast[grant_q]) begin
          last_d  = grant_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state; reset truncates any packet in flight and drops output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_WIDTH'(PORTS - 1);
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      if (beat_acc) begin
        valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Output payload register, loaded only on an accepted beat.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      data_q  <= s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      keep_q  <= s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
      user_q  <= s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
      tlast_q <= s_axis_tlast[grant_q];
      tid_q   <= grant_q;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tvalid = valid_q;
  assign busy          = busy_q;
  assign grant_idx     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_rr_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_axis_packet_rr_arb
// Brief    : Self-checking bench for axis_packet_rr_arb (PORTS=4, 8-bit data).
//            Source queues feed the inputs, expected beats are queued in the
//            predicted grant order, and observed output beats are compared.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_packet_rr_arb;

  localparam int PORTS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [3:0]  s_last;
  logic [3:0]  s_user;
`ifdef AXIS_ARB_PRIO_EN
  logic [3:0]  s_prio;
`endif
  logic [7:0]  m_data;
  logic        m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  m_tid;
  logic        m_user;
  logic        busy;
  logic [1:0]  grant_idx;

  axis_packet_rr_arb #(
    .PORTS(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1), .IDX_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
`ifdef AXIS_ARB_PRIO_EN
    .s_axis_prio(s_prio),
`endif
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tid(m_tid),
    .m_axis_tuser(m_user), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       user;
    logic [1:0] tid;
    logic       last;
  } obs_t;

  beat_t src_q [PORTS][$];
  obs_t  exp_q[$];
  obs_t  obs_q[$];
  int    obs_cyc[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   toggle_ready;
  bit   watch_en;
  int   watch_port;
  int   watch_until;
  bit   watch_done;
  int   watch_rdy_cnt;
  logic busy_before_last;
  logic busy_after_last;

  function automatic obs_t mk(input logic [7:0] d, input logic [1:0] t, input logic l);
    obs_t o;
    o.data = d; o.keep = 1'b1; o.user = d[0]; o.tid = t; o.last = l;
    return o;
  endfunction

  task automatic queue_pkt(input int port, input logic [7:0] d0, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = d0 + 8'(k);
      b.last = (k == n - 1);
      src_q[port].push_back(b);
    end
  endtask

  task automatic expect_pkt(input int port, input logic [7:0] d0, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(d0 + 8'(k), 2'(port), k == n - 1));
  endtask

  // One clock cycle: present queue heads, sample at negedge, retire at posedge.
  task automatic step();
    logic [3:0] acc;
    for (int i = 0; i < PORTS; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i]       = 1'b1;
        s_data[i*8 +: 8] = src_q[i][0].data;
        s_last[i]        = src_q[i][0].last;
        s_user[i]        = src_q[i][0].data[0];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*8 +: 8] = 8'h00;
        s_last[i]        = 1'b0;
        s_user[i]        = 1'b0;
      end
    end
    m_ready = toggle_ready ? ~cyc[0] : 1'b1;
    @(negedge clk);
    acc = s_valid & s_ready;
    if (watch_en && !watch_done && s_ready[watch_port]) watch_rdy_cnt++;
    if (m_valid && m_ready) begin
      obs_q.push_back(obs_t'({m_data, m_keep, m_user, m_tid, m_last}));
      obs_cyc.push_back(cyc);
    end
    if (|(acc & s_last)) busy_before_last = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < PORTS; i++) begin
      if (acc[i]) begin
        if (src_q[i][0].last) begin
          busy_after_last = busy;
          if (watch_en && i == watch_until) watch_done = 1'b1;
        end
        void'(src_q[i].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int budget, output bit timed_out);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      step();
      c++;
    end
    timed_out = (obs_q.size() < n);
  endtask

  task automatic apply_reset();
    for (int i = 0; i < PORTS; i++) src_q[i].delete();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    toggle_ready = 1'b0; watch_en = 1'b0; watch_done = 1'b0; watch_rdy_cnt = 0;
    s_valid = '0; s_last = '0; s_data = '0; s_user = '0; s_keep = 4'hF;
    m_ready = 1'b1;
`ifdef AXIS_ARB_PRIO_EN
    s_prio = '0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 4'hF; s_last = 4'hF; s_data = 32'h33221100; s_user = '0; s_keep = 4'hF;
    m_ready = 1'b1;
`ifdef AXIS_ARB_PRIO_EN
    s_prio = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    checks++; if (s_ready !== 4'h0) begin errors++; $display("FAIL reset_s_ready: got %b want 0000", s_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_first_grant: got %0d want 0", grant_idx); end
  endtask

  task automatic test_single_packet();
    bit to;
    apply_reset();
    queue_pkt(2, 8'h11, 1); queue_pkt(2, 8'h22, 1); queue_pkt(2, 8'h33, 1);
    src_q[2][0].last = 1'b0; src_q[2][1].last = 1'b0;
    exp_q.push_back(mk(8'h11, 2'd2, 1'b0));
    exp_q.push_back(mk(8'h22, 2'd2, 1'b0));
    exp_q.push_back(mk(8'h33, 2'd2, 1'b1));
    busy_before_last = 1'bx; busy_after_last = 1'bx;
    run(3, 30, to);
    checks++; if (to) begin errors++; $display("FAIL t1_timeout: got %0d beats want 3", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t1_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    checks++; if (busy_before_last !== 1'b1) begin errors++; $display("FAIL t1_busy_at_last: got %b want 1", busy_before_last); end
    checks++; if (busy_after_last !== 1'b0) begin errors++; $display("FAIL t1_busy_after_last: got %b want 0", busy_after_last); end
  endtask

  task automatic test_round_robin();
    bit to;
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < PORTS; i++) begin
        queue_pkt(i, 8'(i*16 + p*2), 2);
        expect_pkt(i, 8'(i*16 + p*2), 2);
      end
    run(16, 120, to);
    checks++; if (to) begin errors++; $display("FAIL t2_timeout: got %0d beats want 16", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t2_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    for (int p = 0; p < 7 && 2*p + 2 < obs_cyc.size(); p++) begin
      checks++;
      if (obs_cyc[2*p+2] - obs_cyc[2*p+1] !== 2) begin
        errors++;
        $display("FAIL t2_gap%0d: got %0d cycles want 2", p, obs_cyc[2*p+2] - obs_cyc[2*p+1]);
      end
      checks++;
      if (obs_cyc[2*p+1] - obs_cyc[2*p] !== 1) begin
        errors++;
        $display("FAIL t2_inpkt%0d: got %0d cycles want 1", p, obs_cyc[2*p+1] - obs_cyc[2*p]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    apply_reset();
    toggle_ready = 1'b1;
    watch_en = 1'b1; watch_port = 3; watch_until = 1; watch_done = 1'b0; watch_rdy_cnt = 0;
    queue_pkt(1, 8'h60, 6); expect_pkt(1, 8'h60, 6);
    queue_pkt(3, 8'hA0, 2); expect_pkt(3, 8'hA0, 2);
    run(8, 80, to);
    repeat (6) step();
    checks++; if (to) begin errors++; $display("FAIL t3_timeout: got %0d beats want 8", obs_q.size()); end
    checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL t3_count: got %0d beats want 8", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t3_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    checks++; if (watch_rdy_cnt !== 0) begin errors++; $display("FAIL t3_port3_ready_early: got %0d cycles want 0", watch_rdy_cnt); end
  endtask

  task automatic test_single_beat();
    bit to;
    apply_reset();
    queue_pkt(0, 8'h01, 1); queue_pkt(0, 8'h02, 1);
    queue_pkt(3, 8'h31, 1);
    expect_pkt(0, 8'h01, 1); expect_pkt(3, 8'h31, 1); expect_pkt(0, 8'h02, 1);
    run(3, 30, to);
    checks++; if (to) begin errors++; $display("FAIL t4_timeout: got %0d beats want 3", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t4_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    if (obs_cyc.size() == 3) begin
      checks++;
      if (obs_cyc[2] - obs_cyc[1] !== 2) begin errors++; $display("FAIL t4_gap: got %0d cycles want 2", obs_cyc[2] - obs_cyc[1]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    int c;
    apply_reset();
    queue_pkt(1, 8'h50, 5); expect_pkt(1, 8'h50, 5);
    c = 0;
    while (src_q[1].size() > 3 && c < 30) begin step(); c++; end
    checks++; if (src_q[1].size() != 3) begin errors++; $display("FAIL t5_reach_beat2: got %0d left want 3", src_q[1].size()); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL t5_valid_before: got %b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_on_rst: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_on_rst: got %b want 0", busy); end
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL t5_pre_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL t5_pre_beat: got %h want %h", obs_q[0], exp_q[0]); end
    end
    for (int i = 0; i < PORTS; i++) src_q[i].delete();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(posedge clk); #1 rst = 1'b0;
    queue_pkt(0, 8'hC0, 1); queue_pkt(1, 8'hD0, 1);
    expect_pkt(0, 8'hC0, 1); expect_pkt(1, 8'hD0, 1);
    run(2, 30, to);
    checks++; if (to) begin errors++; $display("FAIL t5_timeout: got %0d beats want 2", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t5_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask

`ifdef AXIS_ARB_PRIO_EN
  task automatic test_priority();
    bit to;
    apply_reset();
    s_prio = 4'b1000;
    queue_pkt(3, 8'h30, 1); queue_pkt(3, 8'h31, 1); queue_pkt(3, 8'h32, 1);
    queue_pkt(0, 8'h40, 1); queue_pkt(1, 8'h41, 1); queue_pkt(2, 8'h42, 1);
    expect_pkt(3, 8'h30, 1); expect_pkt(3, 8'h31, 1); expect_pkt(3, 8'h32, 1);
    expect_pkt(0, 8'h40, 1); expect_pkt(1, 8'h41, 1); expect_pkt(2, 8'h42, 1);
    run(6, 60, to);
    checks++; if (to) begin errors++; $display("FAIL t6_timeout: got %0d beats want 6", obs_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL t6_beat%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();
`ifdef AXIS_ARB_PRIO_EN
    test_priority();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
